// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit control unit: widths, opcodes, instruction
// field positions and FSM state encoding.
package cpu_pkg;

  localparam int unsigned DW  = 8;
  localparam int unsigned IW  = 16;
  localparam int unsigned RAW = 3;

  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RD_LSB  = 9;
  localparam int unsigned RS_LSB  = 6;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_MOV = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_HALT
  } state_t;

  function automatic logic writes_rf(input logic [3:0] op);
    return (op >= OP_LDI) && (op <= OP_XOR);
  endfunction

  function automatic logic is_undef(input logic [3:0] op);
    return (op >= 4'hA) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Instruction-fetch and register-file bus between the control unit and its
// external memory / register file.
interface control_unit_if;
  import cpu_pkg::*;

  logic           imem_req;
  logic [DW-1:0]  imem_addr;
  logic [IW-1:0]  imem_rdata;
  logic           imem_valid;
  logic           rf_wen;
  logic [RAW-1:0] rf_waddr;
  logic [RAW-1:0] rf_saddr;
  logic [DW-1:0]  rf_wdata;
  logic [DW-1:0]  rf_rdata;
  logic [DW-1:0]  rf_sdata;
  logic [DW-1:0]  pc;
  logic           halted;
  logic           illegal;

  modport master (
    output imem_req, imem_addr, rf_wen, rf_waddr, rf_saddr, rf_wdata,
           pc, halted, illegal,
    input  imem_rdata, imem_valid, rf_rdata, rf_sdata
  );

  modport slave (
    input  imem_req, imem_addr, rf_wen, rf_waddr, rf_saddr, rf_wdata,
           pc, halted, illegal,
    output imem_rdata, imem_valid, rf_rdata, rf_sdata
  );

endinterface

// File: rtl/cpu_alu.sv
// Combinational 8-bit ALU; carry is bit 8 of the widened result, which for
// subtraction is the unsigned borrow.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [3:0]    op,
  output logic [DW-1:0] result,
  output logic          carry,
  output logic          zero
);

  logic [DW:0] wide;

  always_comb begin
    wide = '0;
    case (op)
      OP_LDI, OP_MOV: wide = {1'b0, b};
      OP_ADD:         wide = {1'b0, a} + {1'b0, b};
      OP_SUB:         wide = {1'b0, a} - {1'b0, b};
      OP_AND:         wide = {1'b0, a & b};
      OP_OR:          wide = {1'b0, a | b};
      OP_XOR:         wide = {1'b0, a ^ b};
      default:        wide = '0;
    endcase
  end

  assign result = wide[DW-1:0];
  assign carry  = wide[DW];
  assign zero   = (result == '0);

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit: FETCH / DECODE / EXECUTE / HALT sequencing over an
// external instruction memory and external register file.
module control_unit
  import cpu_pkg::*;
#(
  parameter logic [DW-1:0] PC_RESET = 8'h00
) (
  input  logic           clk,
  input  logic           rst,
  control_unit_if.master bus
);

  state_t        state, state_next;
  logic [IW-1:0] ir, ir_next;
  logic [DW-1:0] pc_q, pc_next;
  logic          zf, cf, zf_next, cf_next;

  logic [3:0]    opcode;
  logic [DW-1:0] imm8;
  logic [DW-1:0] alu_b;
  logic [DW-1:0] alu_result;
  logic          alu_carry;
  logic          alu_zero;

  assign opcode = ir[OP_LSB +: 4];
  assign imm8   = ir[IMM_LSB +: DW];
  assign alu_b  = (opcode == OP_LDI) ? imm8 : bus.rf_sdata;

  assign bus.rf_waddr  = ir[RD_LSB +: RAW];
  assign bus.rf_saddr  = ir[RS_LSB +: RAW];
  assign bus.pc        = pc_q;
  assign bus.imem_addr = pc_q;

  cpu_alu u_alu (
    .a      (bus.rf_rdata),
    .b      (alu_b),
    .op     (opcode),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      pc_q  <= PC_RESET;
      ir    <= '0;
      zf    <= 1'b0;
      cf    <= 1'b0;
    end else begin
      state <= state_next;
      pc_q  <= pc_next;
      ir    <= ir_next;
      zf    <= zf_next;
      cf    <= cf_next;
    end
  end

  // Outputs are gated by rst so a reset cycle never requests, writes or flags.
  always_comb begin
    state_next   = state;
    ir_next      = ir;
    pc_next      = pc_q;
    zf_next      = zf;
    cf_next      = cf;
    bus.imem_req = 1'b0;
    bus.rf_wen   = 1'b0;
    bus.rf_wdata = '0;
    bus.halted   = 1'b0;
    bus.illegal  = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          bus.imem_req = 1'b1;
          if (bus.imem_valid) begin
            ir_next    = bus.imem_rdata;
            pc_next    = pc_q + DW'(1);
            state_next = S_DECODE;
          end
        end
        S_DECODE: state_next = S_EXECUTE;
        S_EXECUTE: begin
          state_next = S_FETCH;
          if (writes_rf(opcode)) begin
            bus.rf_wen   = 1'b1;
            bus.rf_wdata = alu_result;
            zf_next      = alu_zero;
            if (opcode >= OP_ADD) cf_next = alu_carry;
          end
          case (opcode)
            OP_JMP:  pc_next = imm8;
            OP_JZ:   if (zf) pc_next = imm8;
            OP_HLT:  state_next = S_HALT;
            default: ;
          endcase
          bus.illegal = is_undef(opcode);
        end
        S_HALT:  bus.halted = 1'b1;
        default: state_next = S_FETCH;
      endcase
    end
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter PC_RESET, default 8'h00, pc value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 imem_req  output  1  instruction fetch request; high in FETCH only.
REQ-005 imem_addr  output  8  fetch address; equals pc.
REQ-006 imem_rdata  input  16  instruction word; sampled only when imem_valid=1 in FETCH.
REQ-007 imem_valid  input  1  fetch data valid; any latency >= 0 cycles after imem_req rises.
REQ-008 rf_wen  output  1  register-file write enable.
REQ-009 rf_waddr  output  3  destination register; equals IR[11:9] at all times.
REQ-010 rf_saddr  output  3  source register; equals IR[8:6] at all times.
REQ-011 rf_wdata  output  8  write data.
REQ-012 rf_rdata  input  8  combinational read of rf_waddr register.
REQ-013 rf_sdata  input  8  combinational read of rf_saddr register.
REQ-014 pc  output  8  current program counter.
REQ-015 halted  output  1  high while in HALT.
REQ-016 illegal  output  1  one-cycle pulse when an undefined opcode executes.

Function
REQ-017 States FETCH, DECODE, EXECUTE, HALT; one instruction = FETCH (>=1 cycle) + DECODE (1) + EXECUTE (1); 3 cycles with zero-wait memory.
REQ-018 FETCH: imem_req=1; on a cycle with imem_valid=1, IR<=imem_rdata, pc<=pc+1 (mod 256, 8'hFF wraps to 8'h00), go to DECODE; otherwise stay.
REQ-019 imem_valid outside FETCH is ignored and has no effect.
REQ-020 DECODE: no outputs change except state; rf_rdata/rf_sdata settle; go to EXECUTE.
REQ-021 Instruction format: [15:12] opcode, [11:9] rd, [8:6] rs, [7:0] imm8.
REQ-022 Opcodes: 0 NOP; 1 LDI rd<=imm8; 2 MOV rd<=rs; 3 ADD rd<=rd+rs; 4 SUB rd<=rd-rs; 5 AND; 6 OR; 7 XOR; 8 JMP pc<=imm8; 9 JZ pc<=imm8 if Z=1; 15 HLT; 10-14 undefined.
REQ-023 EXECUTE: rf_wen=1 for exactly this one cycle for opcodes 1-7, rf_wdata = result; rf_wen=0 in every other state and for other opcodes.
REQ-024 Arithmetic is 8-bit modulo 256; ADD sets C = carry out of bit 7; SUB sets C = 1 when rd < rs (unsigned borrow); AND/OR/XOR clear C; LDI/MOV leave C unchanged.
REQ-025 Z <= (result==0) for opcodes 1-7; Z and C unchanged by NOP, JMP, JZ, HLT, and undefined opcodes.
REQ-026 JMP/JZ-taken overrides the fetch increment; next FETCH uses imm8; JZ not taken continues at the already-incremented pc.
REQ-027 Undefined opcode: behaves as NOP; illegal=1 during that EXECUTE cycle only.
REQ-028 HLT: go to HALT; halted=1; imem_req=0 and rf_wen=0; remain in HALT until rst.
REQ-029 rf_wdata=8'h00 when rf_wen=0.

Reset
REQ-030 While rst=1 at a rising edge: state<=FETCH, pc<=PC_RESET, IR<=16'h0000, Z<=0, C<=0.
REQ-031 During a reset cycle, rf_wen=0, imem_req=0, illegal=0, and halted=0; imem_valid is ignored.
REQ-032 Reset asserted mid-fetch or mid-execute abandons the instruction; no register write occurs in that cycle.
REQ-033 First imem_req after reset occurs in the first cycle with rst=0, with imem_addr=PC_RESET.

Structure
REQ-034 Shared package cpu_pkg holds opcode constants, state encoding, instruction field positions, and data width 8.
REQ-035 ALU is sub-module cpu_alu: combinational; inputs a, b, and op; outputs result, carry, and zero; instantiated once.
REQ-036 The register file is external; control_unit holds no general-purpose registers.

Verification
REQ-037 Zero-wait memory, program LDI R1,5; LDI R2,3; ADD R1,R2: rf_wen pulses in cycles 3, 6, and 9 with rf_wdata 5, 3, and 8; Z=0 and C=0 at end.
REQ-038 Sequence LDI R1,FF; LDI R2,01; ADD R1,R2 -> rf_wdata=00, Z=1, C=1; then SUB R1,R2 (0-1) -> rf_wdata=FF, C=1, Z=0.
REQ-039 imem_valid delayed 3 cycles: imem_req held high 4 cycles with stable imem_addr; pc increments exactly once.
REQ-040 JZ 8'h40 with Z=1 -> next imem_addr=40; with Z=0 -> next imem_addr = old pc+1; pc at FF after fetch wraps to 00.
REQ-041 Opcode 4'hC -> illegal pulses one cycle, no rf_wen; HLT -> halted=1 and imem_req stays 0 for 20 cycles.
REQ-042 rst asserted in the EXECUTE cycle of an ADD -> rf_wen=0 that cycle; next cycle imem_req=1 with imem_addr=PC_RESET.
